// File: rtl/wb_stage.sv
// Write-back stage of the five-stage MIPS pipeline: register-file write, HI/LO,
// the CP0 subset (BadVAddr/Count/Status/Cause/EPC), precise exceptions and ERET.
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY  = 32'hbfc00380,
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         WB_valid,
  input  logic [156:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic [32:0]  exc_bus,
  output logic [31:0]  WB_pc
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  logic        inst_rf_wen;
  logic [31:0] mem_result, lo_result;
  logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall, eret;
  logic [31:0] pc;
  logic        br, true_flagout, isbadaddr;
  logic [31:0] badaddr;
  logic        unused_stop;
  logic        store_isbadaddr, notinst, ri;

  assign {inst_rf_wen, rf_wdest, mem_result, lo_result,
          hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret,
          pc, br, true_flagout, isbadaddr, badaddr,
          unused_stop, store_isbadaddr, notinst, ri} = MEM_WB_bus_r;

  logic [31:0] hi, lo;
  logic [31:0] count, status, cause, epc, badvaddr;
  logic        count_tick;

  logic        live, exc, eret_go, mtc0_go;
  logic [4:0]  exc_code;
  logic        badv_wr;
  logic [31:0] badv_val;
  logic [31:0] cp0_rdata;

  // Reset also gates the live signal so a redirect vanishes the moment reset rises.
  assign live    = WB_valid & ~reset;
  assign exc     = live & (notinst | ri | true_flagout | syscall | isbadaddr | store_isbadaddr);
  assign eret_go = live & eret & ~exc;
  assign mtc0_go = live & mtc0 & ~exc;

  always_comb begin
    exc_code = 5'd0;
    badv_wr  = 1'b0;
    badv_val = pc;
    if (notinst) begin
      exc_code = 5'd4;
      badv_wr  = 1'b1;
      badv_val = pc;
    end else if (ri) begin
      exc_code = 5'd10;
    end else if (true_flagout) begin
      exc_code = 5'd12;
    end else if (syscall) begin
      exc_code = 5'd8;
    end else if (isbadaddr) begin
      exc_code = 5'd4;
      badv_wr  = 1'b1;
      badv_val = badaddr;
    end else if (store_isbadaddr) begin
      exc_code = 5'd5;
      badv_wr  = 1'b1;
      badv_val = badaddr;
    end
  end

  always_comb begin
    case (cp0r_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_STATUS:   cp0_rdata = status;
      ADDR_CAUSE:    cp0_rdata = cause;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = 32'd0;
    endcase
  end

  assign rf_wen   = live & inst_rf_wen & ~exc;
  assign rf_wdata = mfhi ? hi : mflo ? lo : mfc0 ? cp0_rdata : mem_result;
  assign WB_over  = WB_valid;
  assign WB_wdest = rf_wdest & {5{WB_valid}};
  assign WB_pc    = pc;
  assign exc_bus  = exc ? {1'b1, EXC_ENTRY} : eret_go ? {1'b1, epc} : 33'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (live && !exc) begin
      if (hi_write) hi <= mem_result;
      if (lo_write) lo <= lo_result;
    end
  end

  // Count advances every second cycle; a software write restarts the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 32'd0;
      count_tick <= 1'b0;
    end else if (mtc0_go && cp0r_addr == ADDR_COUNT) begin
      count      <= mem_result;
      count_tick <= 1'b0;
    end else begin
      count_tick <= ~count_tick;
      if (count_tick) count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status   <= STATUS_RST;
      cause    <= 32'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
    end else if (exc) begin
      status[1]  <= 1'b1;
      cause[6:2] <= exc_code;
      if (!status[1]) begin
        epc       <= br ? pc - 32'd4 : pc;
        cause[31] <= br;
      end
      if (badv_wr) badvaddr <= badv_val;
    end else if (eret_go) begin
      status[1] <= 1'b0;
    end else if (mtc0_go) begin
      case (cp0r_addr)
        ADDR_STATUS: begin
          status[15:8] <= mem_result[15:8];
          status[1:0]  <= mem_result[1:0];
        end
        ADDR_CAUSE: cause[9:8] <= mem_result[9:8];
        ADDR_EPC:   epc <= mem_result;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: each scenario pushes expected outputs to a
// scoreboard as instructions are driven and pops them when the stage responds.
module tb_wb_stage;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret;
    logic [31:0] pc;
    logic        br, true_flagout, isbadaddr;
    logic [31:0] badaddr;
    logic        stop, store_isbadaddr, notinst, ri;
  } mem_wb_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] wd;
    logic [32:0] exc;
  } exp_t;

  typedef struct packed {
    mem_wb_t     b;
    logic        v;
    logic        wen;
    logic [31:0] wd;
    logic [32:0] exc;
  } stim_t;

  localparam logic [32:0] ENTRY = {1'b1, 32'hbfc00380};
  localparam logic [32:0] NONE  = 33'd0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         WB_valid = 1'b0;
  mem_wb_t      bus = '0;
  logic [156:0] bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic [32:0]  exc_bus;
  logic [31:0]  WB_pc;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  assign bus_r = bus;

  wb_stage dut (
    .clk(clk), .reset(reset), .WB_valid(WB_valid), .MEM_WB_bus_r(bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_bus(exc_bus), .WB_pc(WB_pc)
  );

  always #5 clk = ~clk;

  function automatic mem_wb_t f_base(logic [31:0] pc);
    mem_wb_t b = '0;
    b.pc = pc;
    return b;
  endfunction

  function automatic mem_wb_t f_alu(logic [4:0] d, logic [31:0] r);
    mem_wb_t b = f_base(32'h80000000);
    b.rf_wen = 1'b1; b.rf_wdest = d; b.mem_result = r;
    return b;
  endfunction

  function automatic stim_t st(mem_wb_t b, logic v, logic wen, logic [31:0] wd, logic [32:0] exc);
    stim_t s;
    s.b = b; s.v = v; s.wen = wen; s.wd = wd; s.exc = exc;
    return s;
  endfunction

  function automatic stim_t rd(logic [7:0] a, logic [31:0] val);
    mem_wb_t b = f_alu(5'd2, 32'd0);
    b.mfc0 = 1'b1; b.cp0r_addr = a;
    return st(b, 1'b1, 1'b1, val, NONE);
  endfunction

  function automatic stim_t wr(logic [7:0] a, logic [31:0] d);
    mem_wb_t b = f_base(32'h80000000);
    b.mtc0 = 1'b1; b.cp0r_addr = a; b.mem_result = d;
    return st(b, 1'b1, 1'b0, d, NONE);
  endfunction

  function automatic stim_t er(logic [31:0] target);
    mem_wb_t b = f_base(32'h80000000);
    b.eret = 1'b1;
    return st(b, 1'b1, 1'b0, 32'd0, {1'b1, target});
  endfunction

  function automatic stim_t idle();
    return st('0, 1'b0, 1'b0, 32'd0, NONE);
  endfunction

  task automatic drive(input mem_wb_t b, input logic v);
    @(posedge clk);
    #1;
    bus = b;
    WB_valid = v;
  endtask

  task automatic test_reset();
    stim_t q[$];
    exp_t  e;
    reset = 1'b1;
    WB_valid = 1'b0;
    bus = f_alu(5'd7, 32'h77);
    @(negedge clk);
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset rf_wen: got %b expected 0", rf_wen); end
    n_checks++; if (WB_wdest !== 5'd0) begin n_fail++; $display("[TB] FAIL reset WB_wdest: got %0d expected 0", WB_wdest); end
    n_checks++; if (exc_bus !== NONE) begin n_fail++; $display("[TB] FAIL reset exc_bus: got %h expected %h", exc_bus, NONE); end
    n_checks++; if (WB_over !== 1'b0) begin n_fail++; $display("[TB] FAIL reset WB_over: got %b expected 0", WB_over); end
    n_checks++; if (rf_wdata !== 32'h77) begin n_fail++; $display("[TB] FAIL reset rf_wdata: got %h expected 00000077", rf_wdata); end
    reset = 1'b0;
    q.push_back(rd(8'h60, 32'h00400000));
    q.push_back(rd(8'h70, 32'h0));
    q.push_back(rd(8'h68, 32'h0));
    q.push_back(rd(8'h40, 32'h0));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL reset_cp0[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL reset_cp0[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL reset_cp0[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  task automatic test_addu();
    stim_t q[$];
    exp_t  e;
    q.push_back(st(f_alu(5'd5, 32'h1234), 1'b1, 1'b1, 32'h1234, NONE));
    q.push_back(st(f_alu(5'd9, 32'h77), 1'b0, 1'b0, 32'h77, NONE));
    q.push_back(st(f_alu(5'd31, 32'hffffffff), 1'b1, 1'b1, 32'hffffffff, NONE));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL addu[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL addu[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL addu[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
      n_checks++; if (rf_wdest !== q[i].b.rf_wdest) begin n_fail++; $display("[TB] FAIL addu[%0d] rf_wdest: got %0d expected %0d", i, rf_wdest, q[i].b.rf_wdest); end
      n_checks++; if (WB_over !== q[i].v) begin n_fail++; $display("[TB] FAIL addu[%0d] WB_over: got %b expected %b", i, WB_over, q[i].v); end
      n_checks++; if (WB_wdest !== (q[i].b.rf_wdest & {5{q[i].v}})) begin n_fail++; $display("[TB] FAIL addu[%0d] WB_wdest: got %0d expected %0d", i, WB_wdest, q[i].b.rf_wdest & {5{q[i].v}}); end
    end
  endtask

  task automatic test_exceptions();
    stim_t   q[$];
    exp_t    e;
    mem_wb_t b;
    b = f_alu(5'd3, 32'h99); b.pc = 32'h80000010; b.br = 1'b1; b.true_flagout = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'h99, ENTRY));
    q.push_back(rd(8'h70, 32'h8000000c));
    q.push_back(rd(8'h68, 32'h80000030));
    q.push_back(rd(8'h60, 32'h00400002));
    q.push_back(er(32'h8000000c));
    q.push_back(rd(8'h60, 32'h00400000));
    b = f_alu(5'd8, 32'h5); b.pc = 32'h80000100; b.isbadaddr = 1'b1; b.badaddr = 32'h80001002;
    q.push_back(st(b, 1'b1, 1'b0, 32'h5, ENTRY));
    q.push_back(rd(8'h40, 32'h80001002));
    q.push_back(rd(8'h68, 32'h00000010));
    q.push_back(rd(8'h70, 32'h80000100));
    b = f_base(32'h80000200); b.syscall = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'd0, ENTRY));
    q.push_back(rd(8'h70, 32'h80000100));
    q.push_back(rd(8'h68, 32'h00000020));
    q.push_back(er(32'h80000100));
    q.push_back(rd(8'h60, 32'h00400000));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL exc[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL exc[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL exc[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  task automatic test_priority();
    stim_t   q[$];
    exp_t    e;
    mem_wb_t b;
    b = f_base(32'h80000300); b.ri = 1'b1; b.true_flagout = 1'b1; b.syscall = 1'b1;
    b.isbadaddr = 1'b1; b.badaddr = 32'h1234;
    q.push_back(st(b, 1'b1, 1'b0, 32'd0, ENTRY));
    q.push_back(rd(8'h68, 32'h00000028));
    q.push_back(rd(8'h40, 32'h80001002));
    q.push_back(rd(8'h70, 32'h80000300));
    b = f_base(32'h80000400); b.notinst = 1'b1; b.isbadaddr = 1'b1; b.badaddr = 32'h5678;
    q.push_back(st(b, 1'b1, 1'b0, 32'd0, ENTRY));
    q.push_back(rd(8'h40, 32'h80000400));
    q.push_back(rd(8'h68, 32'h00000010));
    q.push_back(rd(8'h70, 32'h80000300));
    b = f_base(32'h80000500); b.store_isbadaddr = 1'b1; b.badaddr = 32'habcd;
    q.push_back(st(b, 1'b1, 1'b0, 32'd0, ENTRY));
    q.push_back(rd(8'h68, 32'h00000014));
    q.push_back(rd(8'h40, 32'h0000abcd));
    b = f_base(32'h80000600); b.eret = 1'b1; b.syscall = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'd0, ENTRY));
    q.push_back(rd(8'h68, 32'h00000020));
    b = wr(8'h60, 32'h0000ff00).b; b.true_flagout = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'h0000ff00, ENTRY));
    q.push_back(rd(8'h60, 32'h00400002));
    q.push_back(rd(8'h68, 32'h00000030));
    b = wr(8'h70, 32'h11111111).b; b.ri = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'h11111111, ENTRY));
    q.push_back(rd(8'h70, 32'h80000300));
    q.push_back(er(32'h80000300));
    q.push_back(rd(8'h60, 32'h00400000));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL prio[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL prio[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL prio[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  task automatic test_mtc0();
    stim_t q[$];
    exp_t  e;
    q.push_back(wr(8'h60, 32'hffffffff));
    q.push_back(rd(8'h60, 32'h0040ff03));
    q.push_back(wr(8'h60, 32'h00000000));
    q.push_back(rd(8'h60, 32'h00400000));
    q.push_back(wr(8'h68, 32'hffffffff));
    q.push_back(rd(8'h68, 32'h00000328));
    q.push_back(wr(8'h40, 32'h12345678));
    q.push_back(rd(8'h40, 32'h0000abcd));
    q.push_back(wr(8'h50, 32'h87654321));
    q.push_back(rd(8'h50, 32'h00000000));
    q.push_back(wr(8'h70, 32'hdeadbeef));
    q.push_back(er(32'hdeadbeef));
    q.push_back(wr(8'h48, 32'hfffffffe));
    for (int k = 0; k < 4; k++) q.push_back(idle());
    q.push_back(rd(8'h48, 32'h00000000));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL mtc0[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL mtc0[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL mtc0[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  task automatic test_hilo();
    stim_t   q[$];
    exp_t    e;
    mem_wb_t b;
    b = f_base(32'h80000700); b.hi_write = 1'b1; b.lo_write = 1'b1; b.mfhi = 1'b1;
    b.mem_result = 32'hA; b.lo_result = 32'hB;
    q.push_back(st(b, 1'b1, 1'b0, 32'h0, NONE));
    b = f_alu(5'd4, 32'h0); b.mfhi = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'hA, NONE));
    b = f_alu(5'd4, 32'h0); b.mflo = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'hB, NONE));
    b = f_base(32'h80000704); b.hi_write = 1'b1; b.mem_result = 32'h55; b.ri = 1'b1;
    q.push_back(st(b, 1'b1, 1'b0, 32'h55, ENTRY));
    b = f_alu(5'd4, 32'h0); b.mfhi = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'hA, NONE));
    b = f_base(32'h80000708); b.lo_write = 1'b1; b.lo_result = 32'hC;
    q.push_back(st(b, 1'b1, 1'b0, 32'h0, NONE));
    b = f_alu(5'd4, 32'h0); b.mflo = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'hC, NONE));
    b = f_alu(5'd4, 32'h0); b.mfhi = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'hA, NONE));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL hilo[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL hilo[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL hilo[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  task automatic test_reset_mid_run();
    stim_t   q[$];
    exp_t    e;
    mem_wb_t b;
    b = f_base(32'h80000800); b.syscall = 1'b1;
    drive(b, 1'b1);
    @(negedge clk);
    n_checks++; if (exc_bus !== ENTRY) begin n_fail++; $display("[TB] FAIL midreset pre exc_bus: got %h expected %h", exc_bus, ENTRY); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (exc_bus !== NONE) begin n_fail++; $display("[TB] FAIL midreset exc_bus: got %h expected %h", exc_bus, NONE); end
    WB_valid = 1'b0;
    bus = '0;
    @(negedge clk);
    reset = 1'b0;
    b = f_alu(5'd4, 32'h0); b.mfhi = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'h0, NONE));
    b = f_alu(5'd4, 32'h0); b.mflo = 1'b1;
    q.push_back(st(b, 1'b1, 1'b1, 32'h0, NONE));
    q.push_back(rd(8'h60, 32'h00400000));
    q.push_back(rd(8'h70, 32'h0));
    q.push_back(rd(8'h68, 32'h0));
    q.push_back(rd(8'h40, 32'h0));
    foreach (q[i]) begin
      drive(q[i].b, q[i].v);
      sb.push_back(exp_t'{q[i].wen, q[i].wd, q[i].exc});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (rf_wen !== e.wen) begin n_fail++; $display("[TB] FAIL midreset[%0d] rf_wen: got %b expected %b", i, rf_wen, e.wen); end
      n_checks++; if (rf_wdata !== e.wd) begin n_fail++; $display("[TB] FAIL midreset[%0d] rf_wdata: got %h expected %h", i, rf_wdata, e.wd); end
      n_checks++; if (exc_bus !== e.exc) begin n_fail++; $display("[TB] FAIL midreset[%0d] exc_bus: got %h expected %h", i, exc_bus, e.exc); end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_exceptions();
    test_priority();
    test_mtc0();
    test_hilo();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
